floor_gray_encoder: RTL

- Floor-position sequencer for the elevator controller.
- Holds the car's current floor as a binary count and steps it up or down one floor per accepted request, after a fixed transit delay.
- Publishes the floor as a registered Gray code on `gray_o`, emulating the cabin's Gray-coded floor sensor. Downstream Gray-to-binary decoding therefore sees exactly one bit change per floor.

---
 rtl/floor_gray_encoder_if.sv | 42 ++++
 rtl/floor_gray_encoder.sv | 92 +++++++++
 2 files changed

// File: rtl/floor_gray_encoder_if.sv
// Request handshake and floor-status bundle for the floor sequencer.
// The slave side is the sequencer; the master side is the controller issuing step requests.
interface floor_gray_encoder_if #(
  parameter int WIDTH = 3
);
  logic             step_valid_i;
  logic             step_dir_i;
  logic             step_ready_o;
  logic [WIDTH-1:0] gray_o;
  logic [WIDTH-1:0] bin_o;
  logic             moving_o;
  logic             at_top_o;
  logic             at_bottom_o;
  logic             step_done_o;
  logic             step_reject_o;

  modport master (
    output step_valid_i,
    output step_dir_i,
    input  step_ready_o,
    input  gray_o,
    input  bin_o,
    input  moving_o,
    input  at_top_o,
    input  at_bottom_o,
    input  step_done_o,
    input  step_reject_o
  );

  modport slave (
    input  step_valid_i,
    input  step_dir_i,
    output step_ready_o,
    output gray_o,
    output bin_o,
    output moving_o,
    output at_top_o,
    output at_bottom_o,
    output step_done_o,
    output step_reject_o
  );
endinterface

// File: rtl/floor_gray_encoder.sv
// Floor sequencer: steps the binary floor one up/down per accepted request after TRANSIT_CYCLES,
// and mirrors it as a registered Gray code. One request in flight; requests at a limit are refused.
module floor_gray_encoder #(
  parameter int WIDTH          = 3,
  parameter int MAX_FLOOR      = 7,
  parameter int TRANSIT_CYCLES = 4,
  parameter int INIT_FLOOR     = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  floor_gray_encoder_if.slave  bus
);

  localparam int CNT_W = (TRANSIT_CYCLES > 1) ? $clog2(TRANSIT_CYCLES) : 1;
  localparam logic [WIDTH-1:0] W_INIT = WIDTH'(INIT_FLOOR);
  localparam logic [WIDTH-1:0] W_MAX  = WIDTH'(MAX_FLOOR);

  typedef enum logic {
    IDLE    = 1'b0,
    TRANSIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_moving;
  logic             r_done;
  logic             r_reject;

  logic [WIDTH-1:0] w_next_bin;
  logic             w_accept;
  logic             w_at_limit;

  assign w_next_bin = r_dir ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
  assign w_accept   = bus.step_valid_i && (r_state == IDLE);
  // A step that would leave the shaft is refused instead of started, so no wrap can occur.
  assign w_at_limit = bus.step_dir_i ? (r_bin == W_MAX) : (r_bin == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_bin    <= W_INIT;
      r_gray   <= W_INIT ^ (W_INIT >> 1);
      r_moving <= 1'b0;
      r_done   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_at_limit) begin
              r_reject <= 1'b1;
            end else begin
              r_state  <= TRANSIT;
              r_cnt    <= CNT_W'(TRANSIT_CYCLES - 1);
              r_dir    <= bus.step_dir_i;
              r_moving <= 1'b1;
            end
          end
        end
        TRANSIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_bin    <= w_next_bin;
            r_gray   <= w_next_bin ^ (w_next_bin >> 1);
            r_done   <= 1'b1;
            r_moving <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.step_ready_o  = (r_state == IDLE);
  assign bus.gray_o        = r_gray;
  assign bus.bin_o         = r_bin;
  assign bus.moving_o      = r_moving;
  assign bus.at_top_o      = (r_bin == W_MAX);
  assign bus.at_bottom_o   = (r_bin == '0);
  assign bus.step_done_o   = r_done;
  assign bus.step_reject_o = r_reject;

endmodule
